// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, a 2-entry
// {instr, pc} queue toward decode, and redirect handling that squashes stale work.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  input  logic             id_ready
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_KILL = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] INSTR_BYTES = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK  = ~WIDTH'(3);

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] tag;

  logic [WIDTH-1:0] fifo_instr [2];
  logic [WIDTH-1:0] fifo_pc    [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       fifo_count;

  logic             grant;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] redirect_target;

  // A full queue blocks new requests, so a granted response always has a slot.
  assign imem_req        = rst_n && (state == IDLE) && (fifo_count != 2'd2);
  assign imem_addr       = pc;
  assign grant           = imem_req && imem_gnt;
  assign if_valid        = (fifo_count != 2'd0);
  assign if_instr        = fifo_instr[rd_ptr];
  assign if_pc           = fifo_pc[rd_ptr];
  assign pop             = if_valid && id_ready;
  assign push            = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign redirect_target = redirect_pc & ALIGN_MASK;

  // NOTE: sequential state uses <= only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      tag   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) state <= redirect_valid ? WAIT_KILL : WAIT;
        end
        WAIT: begin
          if (imem_rvalid)         state <= IDLE;
          else if (redirect_valid) state <= WAIT_KILL;
        end
        WAIT_KILL: begin
          if (imem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A redirect overrides the increment even when the same cycle was granted.
      if (redirect_valid)  pc <= redirect_target;
      else if (grant)      pc <= pc + INSTR_BYTES;

      if (grant && !redirect_valid) tag <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      // NOTE: the storage is cleared too so if_instr/if_pc read zero out of reset.
      for (int i = 0; i < 2; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]    <= tag;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;

      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  logic [2:0] occupancy;
  assign occupancy = {1'b0, fifo_count} + {2'b00, (state != IDLE)};

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_count == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && fifo_count == 2'd0));
  a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= 3'd2);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for streaming/backpressure plus
// hand sequences for redirects, reset mid-flight and a wrapping RESET_PC.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic        req0, ifv0, req1, ifv1;
  logic [31:0] addr0, instr0, ifpc0, addr1, instr1, ifpc1;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] HI_PC = 32'hFFFF_FFFC;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req0), .imem_addr(addr0), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(ifv0), .if_instr(instr0), .if_pc(ifpc0), .id_ready(id_ready)
  );

  fetch_unit #(.WIDTH(32), .RESET_PC(HI_PC)) dut_hi (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req1), .imem_addr(addr1), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(ifv1), .if_instr(instr1), .if_pc(ifpc1), .id_ready(id_ready)
  );

  typedef struct {
    logic        rst_n;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdy, input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.rst_n = r; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_instr = ei; v.exp_pc = ep;
    v.chk_data = ev || !r;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs after the falling edge, then settle before sampling.
  task automatic step(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                      input logic rdir, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst_n = r; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    redirect_valid = rdir; redirect_pc = rpc; id_ready = rdy;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    //  rst gnt rv rdata          rdy | req addr     v  instr          pc
    add(0, 1, 0, 32'h0,         1,   0, 32'h00,   0, 32'h0,         32'h00); // in reset
    add(1, 1, 0, 32'h0,         1,   1, 32'h00,   0, 32'h0,         32'h00);
    add(1, 1, 1, 32'hA000_0000, 1,   0, 32'h04,   0, 32'h0,         32'h00);
    add(1, 1, 0, 32'h0,         1,   1, 32'h04,   1, 32'hA000_0000, 32'h00);
    add(1, 1, 1, 32'hA000_0004, 1,   0, 32'h08,   0, 32'h0,         32'h00);
    add(1, 1, 0, 32'h0,         1,   1, 32'h08,   1, 32'hA000_0004, 32'h04);
    add(1, 1, 1, 32'hA000_0008, 1,   0, 32'h0C,   0, 32'h0,         32'h00);
    add(1, 1, 0, 32'h0,         0,   1, 32'h0C,   1, 32'hA000_0008, 32'h08); // stall decode
    add(1, 1, 1, 32'hA000_000C, 0,   0, 32'h10,   1, 32'hA000_0008, 32'h08);
    add(1, 1, 0, 32'h0,         0,   0, 32'h10,   1, 32'hA000_0008, 32'h08); // full: no req
    add(1, 1, 0, 32'h0,         0,   0, 32'h10,   1, 32'hA000_0008, 32'h08);
    add(1, 1, 0, 32'h0,         1,   0, 32'h10,   1, 32'hA000_0008, 32'h08); // drain
    add(1, 1, 0, 32'h0,         1,   1, 32'h10,   1, 32'hA000_000C, 32'h0C);
    add(1, 1, 1, 32'hB000_0010, 1,   0, 32'h14,   0, 32'h0,         32'h00);
    add(1, 0, 0, 32'h0,         1,   1, 32'h14,   1, 32'hB000_0010, 32'h10);
    add(1, 0, 1, 32'hDEAD_BEEF, 1,   1, 32'h14,   0, 32'h0,         32'h00); // rvalid in IDLE
    add(1, 0, 0, 32'h0,         1,   1, 32'h14,   0, 32'h0,         32'h00);
    add(1, 1, 0, 32'h0,         0,   1, 32'h14,   0, 32'h0,         32'h00);
    add(1, 1, 1, 32'hC000_0014, 0,   0, 32'h18,   0, 32'h0,         32'h00);
    add(1, 1, 0, 32'h0,         0,   1, 32'h18,   1, 32'hC000_0014, 32'h14);
    add(1, 1, 1, 32'hC000_0018, 1,   0, 32'h1C,   1, 32'hC000_0014, 32'h14); // push+pop
    add(1, 0, 0, 32'h0,         0,   1, 32'h1C,   1, 32'hC000_0018, 32'h18);
    add(1, 0, 0, 32'h0,         1,   1, 32'h1C,   1, 32'hC000_0018, 32'h18);
    add(1, 0, 0, 32'h0,         1,   1, 32'h1C,   0, 32'h0,         32'h00);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, 1'b0, 32'h0, vecs[i].ready);
      check($sformatf("vec%0d imem_req", i), 32'(req0), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d imem_addr", i), addr0, vecs[i].exp_addr);
      check($sformatf("vec%0d if_valid", i), 32'(ifv0), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d if_instr", i), instr0, vecs[i].exp_instr);
        check($sformatf("vec%0d if_pc", i), ifpc0, vecs[i].exp_pc);
      end
      // The high-reset instance runs the same control flow, 4 bytes lower and wrapping.
      check($sformatf("vec%0d hi imem_addr", i), addr1, vecs[i].exp_addr + HI_PC);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d hi if_pc", i), ifpc1, vecs[i].exp_pc + HI_PC);
    end

    // Redirect while WAIT with one entry queued: queue cleared, response dropped.
    step(1, 1, 0, 32'h0,         0, 32'h0,   0); check("rd_wait req a", 32'(req0), 1); check("rd_wait addr a", addr0, 32'h1C);
    step(1, 1, 1, 32'h5555_5555, 0, 32'h0,   0); check("rd_wait req b", 32'(req0), 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,   0); check("rd_wait head", instr0, 32'h5555_5555); check("rd_wait addr c", addr0, 32'h20);
    step(1, 0, 0, 32'h0,         1, 32'h103, 0); check("rd_wait valid pre", 32'(ifv0), 1); check("rd_wait req d", 32'(req0), 0);
    step(1, 1, 1, 32'hBAD0_0000, 0, 32'h0,   1); check("rd_wait killed req", 32'(req0), 0);
    check("rd_wait cleared", 32'(ifv0), 0); check("rd_wait target", addr0, 32'h100);
    step(1, 1, 0, 32'h0,         0, 32'h0,   1); check("rd_wait resume req", 32'(req0), 1);
    check("rd_wait dropped", 32'(ifv0), 0); check("rd_wait resume addr", addr0, 32'h100);

    // Redirect coincident with the response: back to IDLE, response dropped.
    step(1, 0, 1, 32'hBAD0_0001, 1, 32'h200, 1); check("rd_rv req", 32'(req0), 0);
    step(1, 0, 0, 32'h0,         1, 32'h20,  1); check("rd_rv idle req", 32'(req0), 1);
    check("rd_rv no push", 32'(ifv0), 0); check("rd_rv addr", addr0, 32'h200);

    // Redirect in the same cycle as a grant at 0x20, then another while WAIT_KILL.
    step(1, 1, 0, 32'h0,         1, 32'h400, 1); check("rd_gnt req", 32'(req0), 1); check("rd_gnt addr", addr0, 32'h20);
    step(1, 1, 0, 32'h0,         1, 32'h401, 1); check("rd_gnt kill req", 32'(req0), 0); check("rd_gnt kill addr", addr0, 32'h400);
    step(1, 1, 1, 32'hBAD0_0002, 0, 32'h0,   1); check("rd_gnt kill2 req", 32'(req0), 0); check("rd_gnt kill2 addr", addr0, 32'h400);
    step(1, 1, 0, 32'h0,         0, 32'h0,   1); check("rd_gnt new req", 32'(req0), 1);
    check("rd_gnt new addr", addr0, 32'h400); check("rd_gnt discarded", 32'(ifv0), 0);
    step(1, 1, 1, 32'h1111_1111, 0, 32'h0,   1); check("rd_gnt wait addr", addr0, 32'h404);
    step(1, 1, 0, 32'h0,         0, 32'h0,   1); check("rd_gnt instr", instr0, 32'h1111_1111); check("rd_gnt ifpc", ifpc0, 32'h400);

    // Reset for one cycle while WAIT; the late response must be ignored.
    step(0, 0, 0, 32'h0,         0, 32'h0,   1); check("rst_wait req", 32'(req0), 0);
    step(1, 0, 1, 32'h2222_2222, 0, 32'h0,   1); check("rst_rel req", 32'(req0), 1); check("rst_rel addr", addr0, 32'h0);
    check("rst_rel valid", 32'(ifv0), 0); check("rst_rel hi addr", addr1, HI_PC);
    step(1, 0, 0, 32'h0,         0, 32'h0,   1); check("rst_after valid", 32'(ifv0), 0); check("rst_after addr", addr0, 32'h0);
    check("rst_after req", 32'(req0), 1);

    // imem_req is forced low during reset even with IDLE and an empty queue.
    step(0, 0, 0, 32'h0,         0, 32'h0,   1); check("rst_force req", 32'(req0), 0); check("rst_force hi req", 32'(req1), 0);
    step(1, 0, 0, 32'h0,         0, 32'h0,   1); check("rst_end req", 32'(req0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
